// File: rtl/load_store_queue.sv
// In-order load/store queue: program-order dispatch, multi-channel CDB operand snoop,
// head-only memory access through an IDLE/ACCESS/DRAIN FSM, and commit-aware flush.
module load_store_queue #(
  parameter int          ROB_WIDTH = 4,
  parameter int          LSQ_WIDTH = 3,
  parameter int          CDB_PORTS = 2,
  parameter logic [31:0] IO_BASE   = 32'h0003_0000
) (
  input  logic                          clockIn,
  input  logic                          resetIn,
  input  logic                          readyIn,
  input  logic                          clearIn,
  input  logic                          addFlag,
  input  logic [3:0]                    addOp,
  input  logic [31:0]                   addVj,
  input  logic [31:0]                   addVk,
  input  logic [31:0]                   addImm,
  input  logic [ROB_WIDTH-1:0]          addQj,
  input  logic [ROB_WIDTH-1:0]          addQk,
  input  logic                          addQjBusy,
  input  logic                          addQkBusy,
  input  logic [ROB_WIDTH-1:0]          addDest,
  output logic                          full,
  output logic [LSQ_WIDTH:0]            count,
  input  logic [CDB_PORTS-1:0]          cdbFlag,
  input  logic [32*CDB_PORTS-1:0]       cdbVal,
  input  logic [ROB_WIDTH*CDB_PORTS-1:0] cdbDest,
  input  logic                          robFlag,
  input  logic [ROB_WIDTH-1:0]          robDest,
  input  logic [ROB_WIDTH-1:0]          robHeadDest,
  output logic                          outFlag,
  output logic [31:0]                   outVal,
  output logic [ROB_WIDTH-1:0]          outDest,
  output logic                          memOutFlag,
  output logic [2:0]                    memOp,
  output logic [31:0]                   memAddr,
  output logic [31:0]                   memDataOut,
  input  logic [31:0]                   memDataIn,
  input  logic                          memOkFlag
);

  localparam int DEPTH = 1 << LSQ_WIDTH;
  localparam int PW    = (LSQ_WIDTH > 0) ? LSQ_WIDTH : 1;
  localparam int CW    = LSQ_WIDTH + 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DRAIN = 2'd2} state_t;

  typedef struct packed {
    logic                 valid;
    logic                 committed;
    logic [3:0]           op;
    logic [31:0]          vj;
    logic [31:0]          vk;
    logic [31:0]          imm;
    logic [ROB_WIDTH-1:0] qj;
    logic [ROB_WIDTH-1:0] qk;
    logic                 qj_busy;
    logic                 qk_busy;
    logic [ROB_WIDTH-1:0] dest;
  } entry_t;

  entry_t        q [DEPTH];
  logic [PW-1:0] head, tail, youngest;
  logic [CW-1:0] count_r;
  state_t        state;
  logic          mem_req;

  logic [32:0]   snoop_j [DEPTH];
  logic [32:0]   snoop_k [DEPTH];
  logic [32:0]   add_j, add_k;
  logic [CW-1:0] kept;
  entry_t        add_e, head_e;
  logic [31:0]   mem_addr;
  logic          flush, do_add, load_ok, store_ok, issue, mem_done, retire;
  logic [PW-1:0] head_next, flush_tail;
  logic [CW-1:0] flush_count;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? {PW{1'b0}} : p + 1'b1;
  endfunction

  // Lowest CDB channel wins; the internal writeback has the lowest priority.
  function automatic logic [32:0] snoop(input logic [ROB_WIDTH-1:0] tag);
    logic [32:0] r;
    r = (outFlag && outDest == tag) ? {1'b1, outVal} : {1'b0, 32'h0000_0000};
    for (int k = CDB_PORTS - 1; k >= 0; k--) begin
      if (cdbFlag[k] && cdbDest[k*ROB_WIDTH +: ROB_WIDTH] == tag) r = {1'b1, cdbVal[k*32 +: 32]};
      else r = r;
    end
    return r;
  endfunction

  function automatic logic [31:0] load_ext(input logic uns, input logic [1:0] size, input logic [31:0] d);
    logic [31:0] r;
    case (size)
      2'b00:   r = uns ? {24'h00_0000, d[7:0]} : {{24{d[7]}}, d[7:0]};
      2'b01:   r = uns ? {16'h0000, d[15:0]} : {{16{d[15]}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  assign head_e      = q[head];
  assign mem_addr    = head_e.vj + head_e.imm;
  assign memAddr     = mem_addr;
  assign memDataOut  = head_e.vk;
  assign memOutFlag  = mem_req & ~memOkFlag;
  assign count       = count_r;
  assign full        = (count_r == CW'(DEPTH));

  assign flush       = readyIn & clearIn;
  assign do_add      = readyIn & addFlag & ~full & ~flush;
  assign load_ok     = !head_e.op[3] && !head_e.qj_busy && !flush &&
                       ((mem_addr < IO_BASE) || (head_e.dest == robHeadDest));
  assign store_ok    = head_e.op[3] && head_e.committed && !head_e.qj_busy && !head_e.qk_busy;
  assign issue       = head_e.valid && (load_ok || store_ok);
  assign mem_done    = readyIn && memOkFlag && (state == ACCESS);
  // A load squashed in the completion cycle is dropped instead of retired.
  assign retire      = mem_done && (head_e.op[3] || !flush);
  assign head_next   = retire ? ptr_inc(head) : head;
  assign flush_tail  = (q[youngest].valid && q[youngest].committed) ? ptr_inc(youngest) : head_next;
  assign flush_count = kept - CW'(retire);

  // Snoop results per entry, surviving committed entries, and the entry being dispatched.
  always_comb begin
    kept  = '0;
    add_j = snoop(addQj);
    add_k = snoop(addQk);
    for (int i = 0; i < DEPTH; i++) begin
      snoop_j[i] = snoop(q[i].qj);
      snoop_k[i] = snoop(q[i].qk);
      if (q[i].valid && q[i].committed) kept = kept + 1'b1;
      else kept = kept;
    end
    add_e           = '0;
    add_e.valid     = 1'b1;
    add_e.op        = addOp;
    add_e.imm       = addImm;
    add_e.qj        = addQj;
    add_e.qk        = addQk;
    add_e.dest      = addDest;
    add_e.vj        = (addQjBusy && add_j[32]) ? add_j[31:0] : addVj;
    add_e.vk        = (addQkBusy && add_k[32]) ? add_k[31:0] : addVk;
    add_e.qj_busy   = addQjBusy && !add_j[32];
    add_e.qk_busy   = addQkBusy && !add_k[32];
  end

  // Queue storage, pointers, commit/flush bookkeeping and the memory FSM.
  always_ff @(posedge clockIn or posedge resetIn) begin
    if (resetIn) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      head     <= '0;
      tail     <= '0;
      youngest <= '0;
      count_r  <= '0;
      state    <= IDLE;
      mem_req  <= 1'b0;
      memOp    <= 3'b000;
      outFlag  <= 1'b0;
      outVal   <= 32'h0000_0000;
      outDest  <= '0;
    end else if (readyIn) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (q[i].valid && q[i].qj_busy && snoop_j[i][32]) begin
          q[i].vj      <= snoop_j[i][31:0];
          q[i].qj_busy <= 1'b0;
        end
        if (q[i].valid && q[i].qk_busy && snoop_k[i][32]) begin
          q[i].vk      <= snoop_k[i][31:0];
          q[i].qk_busy <= 1'b0;
        end
        if (robFlag && !flush && q[i].valid && !q[i].committed && q[i].dest == robDest) begin
          q[i].committed <= 1'b1;
          youngest       <= PW'(i);
        end
        if (flush && !q[i].committed) q[i].valid <= 1'b0;
      end

      if (do_add) q[tail] <= add_e;
      if (retire) q[head].valid <= 1'b0;
      head <= head_next;

      if (flush) begin
        tail    <= flush_tail;
        count_r <= flush_count;
      end else begin
        if (do_add) tail <= ptr_inc(tail);
        count_r <= count_r + CW'(do_add) - CW'(retire);
      end

      outFlag <= 1'b0;
      case (state)
        IDLE: begin
          if (issue) begin
            state   <= ACCESS;
            mem_req <= 1'b1;
            memOp   <= {head_e.op[3], head_e.op[1:0]};
          end
        end
        ACCESS: begin
          if (memOkFlag) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            if (!head_e.op[3] && !flush) begin
              outFlag <= 1'b1;
              outVal  <= load_ext(head_e.op[2], head_e.op[1:0], memDataIn);
              outDest <= head_e.dest;
            end
          end else if (flush && !head_e.op[3]) begin
            state   <= DRAIN;
            mem_req <= 1'b0;
          end
        end
        DRAIN: begin
          if (memOkFlag) state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_queue.sv
// Directed self-checking bench for load_store_queue with hand-computed expectations.
module tb_load_store_queue;

  logic        clk = 1'b0;
  logic        resetIn, readyIn, clearIn, addFlag;
  logic [3:0]  addOp;
  logic [31:0] addVj, addVk, addImm;
  logic [3:0]  addQj, addQk, addDest;
  logic        addQjBusy, addQkBusy;
  logic        full;
  logic [3:0]  count;
  logic [1:0]  cdbFlag;
  logic [63:0] cdbVal;
  logic [7:0]  cdbDest;
  logic        robFlag;
  logic [3:0]  robDest, robHeadDest;
  logic        outFlag;
  logic [31:0] outVal;
  logic [3:0]  outDest;
  logic        memOutFlag;
  logic [2:0]  memOp;
  logic [31:0] memAddr, memDataOut, memDataIn;
  logic        memOkFlag;

  int checks = 0;
  int failures = 0;

  load_store_queue dut (
    .clockIn(clk), .resetIn(resetIn), .readyIn(readyIn), .clearIn(clearIn),
    .addFlag(addFlag), .addOp(addOp), .addVj(addVj), .addVk(addVk), .addImm(addImm),
    .addQj(addQj), .addQk(addQk), .addQjBusy(addQjBusy), .addQkBusy(addQkBusy),
    .addDest(addDest), .full(full), .count(count),
    .cdbFlag(cdbFlag), .cdbVal(cdbVal), .cdbDest(cdbDest),
    .robFlag(robFlag), .robDest(robDest), .robHeadDest(robHeadDest),
    .outFlag(outFlag), .outVal(outVal), .outDest(outDest),
    .memOutFlag(memOutFlag), .memOp(memOp), .memAddr(memAddr), .memDataOut(memDataOut),
    .memDataIn(memDataIn), .memOkFlag(memOkFlag)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input logic [3:0] op, input logic [31:0] vj, input logic [31:0] vk,
                          input logic [31:0] imm, input logic [3:0] dest,
                          input logic qjb, input logic [3:0] qj);
    addFlag = 1'b1; addOp = op; addVj = vj; addVk = vk; addImm = imm; addDest = dest;
    addQjBusy = qjb; addQj = qj; addQkBusy = 1'b0; addQk = 4'd0;
    tick();
    addFlag = 1'b0;
  endtask

  task automatic mem_finish(input logic [31:0] data);
    memDataIn = data;
    memOkFlag = 1'b1;
    tick();
    memOkFlag = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    for (int n = 0; n < 20; n++) begin
      if (memOutFlag) break;
      tick();
    end
    check_eq(tag, {31'd0, memOutFlag}, 32'd1);
  endtask

  initial begin
    resetIn = 1'b1; readyIn = 1'b1; clearIn = 1'b0; addFlag = 1'b0; addOp = 4'd0;
    addVj = 32'd0; addVk = 32'd0; addImm = 32'd0; addQj = 4'd0; addQk = 4'd0; addDest = 4'd0;
    addQjBusy = 1'b0; addQkBusy = 1'b0; cdbFlag = 2'b00; cdbVal = 64'd0; cdbDest = 8'd0;
    robFlag = 1'b0; robDest = 4'd0; robHeadDest = 4'd0; memDataIn = 32'd0; memOkFlag = 1'b0;
    tick(); tick();
    resetIn = 1'b0;
    tick();
    check_eq("rst_full", {31'd0, full}, 32'd0);
    check_eq("rst_count", {28'd0, count}, 32'd0);
    check_eq("rst_outflag", {31'd0, outFlag}, 32'd0);
    check_eq("rst_outval", outVal, 32'd0);
    check_eq("rst_outdest", {28'd0, outDest}, 32'd0);
    check_eq("rst_memreq", {31'd0, memOutFlag}, 32'd0);
    check_eq("rst_memop", {29'd0, memOp}, 32'd0);

    // signed byte load
    dispatch(4'b0000, 32'h100, 32'd0, 32'd0, 4'd5, 1'b0, 4'd0);
    check_eq("sb_count", {28'd0, count}, 32'd1);
    check_eq("sb_noreq_yet", {31'd0, memOutFlag}, 32'd0);
    tick();
    check_eq("sb_req", {31'd0, memOutFlag}, 32'd1);
    check_eq("sb_addr", memAddr, 32'h100);
    check_eq("sb_memop", {29'd0, memOp}, 32'd0);
    memDataIn = 32'h0000_0080; memOkFlag = 1'b1; #1;
    check_eq("sb_req_masked", {31'd0, memOutFlag}, 32'd0);
    tick(); memOkFlag = 1'b0;
    check_eq("sb_outflag", {31'd0, outFlag}, 32'd1);
    check_eq("sb_outval", outVal, 32'hFFFF_FF80);
    check_eq("sb_outdest", {28'd0, outDest}, 32'd5);
    check_eq("sb_count_after", {28'd0, count}, 32'd0);
    tick();
    check_eq("sb_outflag_pulse", {31'd0, outFlag}, 32'd0);

    // unsigned half load
    dispatch(4'b0101, 32'h200, 32'd0, 32'd0, 4'd6, 1'b0, 4'd0);
    wait_req("uh_req");
    check_eq("uh_memop", {29'd0, memOp}, 32'd1);
    mem_finish(32'hABCD_8001);
    check_eq("uh_outval", outVal, 32'h0000_8001);

    // internal writeback forwarding into a dependent load
    dispatch(4'b0011, 32'h1000, 32'd0, 32'd0, 4'd1, 1'b0, 4'd0);
    dispatch(4'b0011, 32'd0, 32'd0, 32'h10, 4'd2, 1'b1, 4'd1);
    check_eq("fw_addr_a", memAddr, 32'h1000);
    mem_finish(32'h20);
    check_eq("fw_outval_a", outVal, 32'h20);
    wait_req("fw_req_b");
    check_eq("fw_addr_b", memAddr, 32'h30);
    mem_finish(32'h99);
    check_eq("fw_outdest_b", {28'd0, outDest}, 32'd2);

    // CDB capture, lowest channel wins on duplicate tags
    dispatch(4'b0011, 32'd0, 32'd0, 32'h4, 4'd3, 1'b1, 4'd7);
    check_eq("cdb_wait", {31'd0, memOutFlag}, 32'd0);
    cdbFlag = 2'b11; cdbDest = {4'd7, 4'd7}; cdbVal = {32'h400, 32'h300};
    tick();
    cdbFlag = 2'b00;
    wait_req("cdb_req");
    check_eq("cdb_addr", memAddr, 32'h304);
    mem_finish(32'd0);

    // IO load held until it reaches the ROB head
    robHeadDest = 4'd1;
    dispatch(4'b0011, 32'h0003_0000, 32'd0, 32'd0, 4'd3, 1'b0, 4'd0);
    tick(); tick();
    check_eq("io_held", {31'd0, memOutFlag}, 32'd0);
    robHeadDest = 4'd3;
    tick();
    check_eq("io_req", {31'd0, memOutFlag}, 32'd1);
    mem_finish(32'h1234_5678);
    check_eq("io_outval", outVal, 32'h1234_5678);

    // fill to depth, refused ninth, retire with refused dispatch, wrap, flush
    for (int i = 0; i < 8; i++)
      dispatch(4'b1011, 32'h2000, 32'h1000 + 32'(i), 32'(4 * i), 4'(i), 1'b0, 4'd0);
    check_eq("fill_count", {28'd0, count}, 32'd8);
    check_eq("fill_full", {31'd0, full}, 32'd1);
    dispatch(4'b1011, 32'h2000, 32'd0, 32'd0, 4'd15, 1'b0, 4'd0);
    check_eq("ninth_ignored", {28'd0, count}, 32'd8);
    robFlag = 1'b1; robDest = 4'd0;
    tick();
    robFlag = 1'b0;
    wait_req("st_req");
    check_eq("st_memop", {29'd0, memOp}, 32'd7);
    check_eq("st_addr", memAddr, 32'h2000);
    check_eq("st_data", memDataOut, 32'h1000);
    memOkFlag = 1'b1;
    dispatch(4'b1011, 32'h2000, 32'd0, 32'd0, 4'd14, 1'b0, 4'd0);
    memOkFlag = 1'b0;
    check_eq("retire_count", {28'd0, count}, 32'd7);
    check_eq("retire_full", {31'd0, full}, 32'd0);
    check_eq("st_no_outflag", {31'd0, outFlag}, 32'd0);
    dispatch(4'b1011, 32'h2000, 32'd0, 32'd0, 4'd13, 1'b0, 4'd0);
    check_eq("refill_full", {31'd0, full}, 32'd1);
    clearIn = 1'b1; tick(); clearIn = 1'b0;
    check_eq("flush_all_count", {28'd0, count}, 32'd0);

    // flush while a committed store is in ACCESS
    dispatch(4'b1011, 32'h500, 32'hCAFE, 32'd0, 4'd8, 1'b0, 4'd0);
    dispatch(4'b0011, 32'h600, 32'd0, 32'd0, 4'd9, 1'b0, 4'd0);
    robFlag = 1'b1; robDest = 4'd8; tick(); robFlag = 1'b0;
    tick();
    check_eq("cs_req", {31'd0, memOutFlag}, 32'd1);
    check_eq("cs_data", memDataOut, 32'hCAFE);
    clearIn = 1'b1; tick(); clearIn = 1'b0;
    check_eq("cs_flush_count", {28'd0, count}, 32'd1);
    check_eq("cs_store_continues", {31'd0, memOutFlag}, 32'd1);
    mem_finish(32'd0);
    check_eq("cs_count_zero", {28'd0, count}, 32'd0);
    tick(); tick();
    check_eq("cs_no_reissue", {31'd0, memOutFlag}, 32'd0);

    // flush during load ACCESS drains the stale completion
    dispatch(4'b0011, 32'h700, 32'd0, 32'd0, 4'd10, 1'b0, 4'd0);
    tick();
    check_eq("dr_req", {31'd0, memOutFlag}, 32'd1);
    clearIn = 1'b1; tick(); clearIn = 1'b0;
    check_eq("dr_req_dropped", {31'd0, memOutFlag}, 32'd0);
    check_eq("dr_count", {28'd0, count}, 32'd0);
    dispatch(4'b0011, 32'h800, 32'd0, 32'd0, 4'd11, 1'b0, 4'd0);
    tick();
    check_eq("dr_hold_issue", {31'd0, memOutFlag}, 32'd0);
    mem_finish(32'hDEAD);
    check_eq("dr_no_outflag", {31'd0, outFlag}, 32'd0);
    tick();
    check_eq("dr_next_req", {31'd0, memOutFlag}, 32'd1);
    check_eq("dr_next_addr", memAddr, 32'h800);
    mem_finish(32'h55);
    check_eq("dr_next_outdest", {28'd0, outDest}, 32'd11);
    check_eq("dr_next_outval", outVal, 32'h55);

    // readyIn low freezes dispatch
    readyIn = 1'b0;
    dispatch(4'b0011, 32'h900, 32'd0, 32'd0, 4'd12, 1'b0, 4'd0);
    check_eq("frz_count", {28'd0, count}, 32'd0);
    readyIn = 1'b1;

    // asynchronous reset mid-ACCESS
    dispatch(4'b0011, 32'hA00, 32'd0, 32'd0, 4'd12, 1'b0, 4'd0);
    tick();
    check_eq("ar_req", {31'd0, memOutFlag}, 32'd1);
    #2 resetIn = 1'b1;
    #1;
    check_eq("ar_memreq", {31'd0, memOutFlag}, 32'd0);
    check_eq("ar_count", {28'd0, count}, 32'd0);
    tick();
    resetIn = 1'b0;
    tick();
    check_eq("ar_idle", {31'd0, memOutFlag}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
